// File: rtl/slicem_pkg.sv
// Shared types and helpers for the SLICEM-style LUT RAM.
package slicem_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Total number of serial configuration bits across all bit-planes.
    function automatic int unsigned CFG_BITS(input int unsigned mem_size,
                                             input int unsigned width);
        return mem_size * width;
    endfunction

endpackage

// File: rtl/slicem_lutram_plane.sv
// One LUT RAM bit-plane: serial-config bit write, user write, two async reads.
// Optional shift-register mode is built when SLICEM_SRL_EN is defined.
module lutram_plane #(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned MEM_SIZE  = 2**ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cfg_we,
    input  logic [ADDR_BITS-1:0] i_cfg_addr,
    input  logic                 i_cfg_bit,
    input  logic                 i_user_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic                 i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic                 o_rdata,
    output logic                 o_dpo
`ifdef SLICEM_SRL_EN
    ,
    input  logic                 i_shift_en,
    input  logic                 i_shift_in,
    output logic                 o_shift_out
`endif
);

    logic [MEM_SIZE-1:0] r_mem;

    // Storage update; the top guarantees at most one of the enables is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_cfg_we) begin
            r_mem[i_cfg_addr] <= i_cfg_bit;
`ifdef SLICEM_SRL_EN
        end else if (i_shift_en) begin
            r_mem <= {r_mem[MEM_SIZE-2:0], i_shift_in};
`endif
        end else if (i_user_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
    assign o_dpo   = r_mem[i_waddr];
`ifdef SLICEM_SRL_EN
    assign o_shift_out = r_mem[MEM_SIZE-1];
`endif

endmodule

// File: rtl/slicem_lutram.sv
// SLICEM-style distributed RAM: serially configured LUT bit-planes with a
// user write port and dual combinational reads.
// Optional feature macro: SLICEM_SRL_EN adds the shift-register ports.
module slicem_lutram
    import slicem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned MEM_SIZE  = 2**ADDR_BITS,
    parameter int unsigned WIDTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic                 config_in,
    output logic                 config_done,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [WIDTH-1:0]     out,
    input  logic [ADDR_BITS-1:0] waddr,
    output logic [WIDTH-1:0]     dpo,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 write_en
`ifdef SLICEM_SRL_EN
    ,
    input  logic                 shift_en,
    input  logic [WIDTH-1:0]     shift_in,
    output logic [WIDTH-1:0]     shift_out
`endif
);

    localparam int unsigned N_CFG = CFG_BITS(MEM_SIZE, WIDTH);
    localparam int unsigned CNT_W = $clog2(N_CFG) + 1;
    localparam int unsigned LAST  = N_CFG - 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_config_done;
    logic               w_done_next;
    logic               w_cfg_write;
    logic               w_user_we;
    logic [CNT_W-1:0]   w_cfg_plane;
    logic [ADDR_BITS-1:0] w_cfg_entry;
    logic               w_last_bit;
`ifdef SLICEM_SRL_EN
    logic               w_shift;
`endif

    assign w_last_bit = (r_cnt == CNT_W'(LAST));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UNCFG;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            UNCFG:   if (cen) w_state_next = LOAD;
            LOAD:    if (cen && w_last_bit) w_state_next = RUN;
            RUN:     if (cen) w_state_next = LOAD;
            default: w_state_next = UNCFG;
        endcase
    end

    // Control decode. The UNCFG->LOAD edge already captures bit 0, so a load
    // from reset takes exactly N_CFG enabled cycles; RUN->LOAD only rewinds cnt.
    always_comb begin
        w_cfg_write = cen && ((r_state == UNCFG) || (r_state == LOAD));
        w_cnt_next  = r_cnt;
        if (w_cfg_write) begin
            w_cnt_next = w_last_bit ? '0 : r_cnt + CNT_W'(1);
        end else if ((r_state == RUN) && cen) begin
            w_cnt_next = '0;
        end
`ifdef SLICEM_SRL_EN
        w_shift     = (r_state == RUN) && !cen && shift_en;
        w_user_we   = (r_state == RUN) && !cen && write_en && !shift_en;
`else
        w_user_we   = (r_state == RUN) && !cen && write_en;
`endif
        w_done_next = (w_state_next == RUN);
        w_cfg_plane = r_cnt / CNT_W'(MEM_SIZE);
        w_cfg_entry = ADDR_BITS'(r_cnt % CNT_W'(MEM_SIZE));
    end

    // Bit counter and load-complete flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_config_done <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_config_done <= w_done_next;
        end
    end

    assign config_done = r_config_done;

    for (genvar p = 0; p < WIDTH; p++) begin : g_plane
        logic w_cfg_we;
        assign w_cfg_we = w_cfg_write && (w_cfg_plane == CNT_W'(p));

        lutram_plane #(
            .ADDR_BITS (ADDR_BITS),
            .MEM_SIZE  (MEM_SIZE)
        ) u_plane (
            .clk        (clk),
            .rst        (rst),
            .i_cfg_we   (w_cfg_we),
            .i_cfg_addr (w_cfg_entry),
            .i_cfg_bit  (config_in),
            .i_user_we  (w_user_we),
            .i_waddr    (waddr),
            .i_wdata    (data_in[p]),
            .i_raddr    (addr),
            .o_rdata    (out[p]),
            .o_dpo      (dpo[p])
`ifdef SLICEM_SRL_EN
            ,
            .i_shift_en (w_shift),
            .i_shift_in (shift_in[p]),
            .o_shift_out(shift_out[p])
`endif
        );
    end

endmodule

// File: tb/tb_slicem_lutram.sv
// Randomized self-checking bench for slicem_lutram against an array model.
module tb_slicem_lutram;

    localparam int AB  = 4;
    localparam int MEM = 16;
    localparam int W   = 2;
    localparam int NCFG = MEM * W;
`ifdef SLICEM_SRL_EN
    localparam bit SRL = 1'b1;
`else
    localparam bit SRL = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          cen;
    logic          config_in;
    logic          config_done;
    logic [AB-1:0] addr;
    logic [W-1:0]  out;
    logic [AB-1:0] waddr;
    logic [W-1:0]  dpo;
    logic [W-1:0]  data_in;
    logic          write_en;
`ifdef SLICEM_SRL_EN
    logic          shift_en;
    logic [W-1:0]  shift_in;
    logic [W-1:0]  shift_out;
`endif

    slicem_lutram #(.ADDR_BITS(AB), .MEM_SIZE(MEM), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .config_in  (config_in),
        .config_done(config_done),
        .addr       (addr),
        .out        (out),
        .waddr      (waddr),
        .dpo        (dpo),
        .data_in    (data_in),
        .write_en   (write_en)
`ifdef SLICEM_SRL_EN
        ,
        .shift_en   (shift_en),
        .shift_in   (shift_in),
        .shift_out  (shift_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the memory image, whether a complete image is live,
    // whether a load is in progress, and how many bits of it have arrived.
    bit ref_mem [W][MEM];
    bit m_running;
    bit m_loading;
    int m_bits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_word(input int a);
        logic [W-1:0] v;
        for (int p = 0; p < W; p++) v[p] = ref_mem[p][a];
        return v;
    endfunction

    function automatic void model_clear();
        for (int p = 0; p < W; p++)
            for (int i = 0; i < MEM; i++) ref_mem[p][i] = 1'b0;
        m_running = 1'b0;
        m_loading = 1'b0;
        m_bits    = 0;
    endfunction

    // One clock: drive, compare combinational outputs pre-edge, then advance model.
    task automatic step(input logic t_rst, input logic t_cen, input logic t_cfg,
                        input logic [AB-1:0] t_addr, input logic [AB-1:0] t_waddr,
                        input logic [W-1:0] t_din, input logic t_we,
                        input logic t_sh, input logic [W-1:0] t_shin);
        @(negedge clk);
        rst = t_rst; cen = t_cen; config_in = t_cfg;
        addr = t_addr; waddr = t_waddr; data_in = t_din; write_en = t_we;
`ifdef SLICEM_SRL_EN
        shift_en = t_sh; shift_in = t_shin;
`endif
        #1;
        check("out", 32'(out), 32'(ref_word(int'(t_addr))));
        check("dpo", 32'(dpo), 32'(ref_word(int'(t_waddr))));
        check("done", 32'(config_done), 32'(m_running));
`ifdef SLICEM_SRL_EN
        check("sout", 32'(shift_out), 32'(ref_word(MEM-1)));
`endif
        @(posedge clk);
        if (t_rst) begin
            model_clear();
        end else if (t_cen) begin
            if (m_running) begin
                m_running = 1'b0;
                m_loading = 1'b1;
                m_bits    = 0;
            end else begin
                ref_mem[m_bits / MEM][m_bits % MEM] = t_cfg;
                m_bits++;
                m_loading = 1'b1;
                if (m_bits == NCFG) begin
                    m_running = 1'b1;
                    m_loading = 1'b0;
                    m_bits    = 0;
                end
            end
        end else if (m_running) begin
            if (SRL && t_sh) begin
                for (int p = 0; p < W; p++) begin
                    for (int i = MEM-1; i > 0; i--) ref_mem[p][i] = ref_mem[p][i-1];
                    ref_mem[p][0] = t_shin[p];
                end
            end else if (t_we) begin
                for (int p = 0; p < W; p++) ref_mem[p][t_waddr] = t_din[p];
            end
        end
    endtask

    // Park inputs idle and let comb outputs settle for a direct look.
    task automatic peek(input logic [AB-1:0] a, input logic [AB-1:0] wa);
        @(negedge clk);
        rst = 1'b0; cen = 1'b0; write_en = 1'b0;
`ifdef SLICEM_SRL_EN
        shift_en = 1'b0;
`endif
        addr = a; waddr = wa;
        #1;
    endtask

    task automatic load_word(input logic [31:0] pat, input int first, input int last);
        for (int i = first; i <= last; i++)
            step(1'b0, 1'b1, pat[i], AB'($urandom), AB'($urandom), W'($urandom),
                 1'($urandom), 1'($urandom), W'($urandom));
    endtask

    task automatic check_image(input string tag, input logic [31:0] pat);
        for (int a = 0; a < MEM; a++) begin
            peek(AB'(a), AB'(MEM-1-a));
            check({tag, "_out"}, 32'(out), 32'({pat[MEM+a], pat[a]}));
            check({tag, "_dpo"}, 32'(dpo), 32'({pat[2*MEM-1-a], pat[MEM-1-a]}));
        end
    endtask

    logic [31:0] pat_a;
    logic [31:0] pat_q;
    logic [W-1:0] old_v;

    initial begin
        rst = 1'b1; cen = 1'b0; config_in = 1'b0; addr = '0; waddr = '0;
        data_in = '0; write_en = 1'b0;
`ifdef SLICEM_SRL_EN
        shift_en = 1'b0; shift_in = '0;
`endif
        repeat (2) @(posedge clk);
        model_clear();
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, '1);

        // Post-reset reads, with write strobes that must be ignored while unconfigured.
        for (int a = 0; a < MEM; a++)
            step(1'b0, 1'b0, 1'b0, AB'(a), AB'(MEM-1-a), W'($urandom), 1'b1, 1'b1, '1);
        check_image("rst", 32'h0);
        check("rst_done", 32'(config_done), 32'h0);

        // Full load of the reference pattern, LSB first.
        pat_a = 32'hA5A5_F00F;
        load_word(pat_a, 0, NCFG-1);
        peek('0, '0);
        check("load_done", 32'(config_done), 32'h1);
        check("load_addr0", 32'(out), 32'h3);
        check_image("load_a", pat_a);

        // Reload with a mid-load pause; strobes during the pause are ignored.
        pat_q = $urandom;
        step(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        load_word(pat_q, 0, 15);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b0, AB'($urandom), AB'($urandom), W'($urandom), 1'b1, 1'b1, W'($urandom));
        load_word(pat_q, 16, NCFG-1);
        check_image("pause", pat_q);

        // User write with read-during-write on the same address.
        old_v = {pat_q[MEM+3], pat_q[3]};
        peek(AB'(3), AB'(3));
        check("wr_before", 32'(out), 32'(old_v));
        step(1'b0, 1'b0, 1'b0, AB'(3), AB'(3), 2'b10, 1'b1, 1'b0, '0);
        peek(AB'(3), AB'(3));
        check("wr_out", 32'(out), 32'h2);
        check("wr_dpo", 32'(dpo), 32'h2);

        // Random user traffic in RUN.
        for (int i = 0; i < 300; i++)
            step(1'b0, 1'b0, 1'b0, AB'($urandom), AB'($urandom), W'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) == 0), W'($urandom));

        // Reset in the middle of a reload, then a clean reload.
        step(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        load_word(32'hFFFF_FFFF, 0, 19);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        check_image("midrst", 32'h0);
        check("midrst_done", 32'(config_done), 32'h0);
        pat_q = $urandom;
        load_word(pat_q, 0, NCFG-2);
        peek('0, '0);
        check("reload_31", 32'(config_done), 32'h0);
        load_word(pat_q, NCFG-1, NCFG-1);
        peek('0, '0);
        check("reload_32", 32'(config_done), 32'h1);
        check_image("reload", pat_q);

`ifdef SLICEM_SRL_EN
        // Sixteen shifts of 2'b01 fill every entry; concurrent writes are dropped.
        for (int i = 0; i < MEM; i++)
            step(1'b0, 1'b0, 1'b0, AB'($urandom), AB'($urandom), 2'b10, 1'b1, 1'b1, 2'b01);
        peek('0, '0);
        check("srl_out", 32'(shift_out), 32'h1);
        check_image("srl", {16'h0000, 16'hFFFF});
`endif

        // Mixed random traffic including loads, pauses and occasional resets.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom),
                 AB'($urandom), AB'($urandom), W'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) == 0), W'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
